fd_pipe_reg: RTL and testbench
==============================

FD_PIPE_REG -- requirements
Module: fd_pipe_reg

Interface
REQ-001 SHALL have exactly one clock; reset is asynchronous and active-high (CLK, RESET).
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  asynchronous active-high reset.
REQ-004 F_PC  input  32  fetch-stage PC of the instruction being fetched.
REQ-005 F_Instr  input  32  instruction word read from instruction memory at F_PC.
REQ-006 F_BD  input  1  fetched instruction sits in a branch delay slot.
REQ-007 WE  input  1  stage enable; 0 = stall (hold), 1 = advance.
REQ-008 Req  input  1  exception/interrupt request; flush stage toward handler.
REQ-009 Clr  input  1  squash the incoming instruction (annulled delay slot) when advancing.
REQ-010 D_PC  output  32  registered PC for decode stage.
REQ-011 D_Instr  output  32  registered instruction, or 0 (nop) for a bubble or faulting fetch.
REQ-012 D_BD  output  1  registered delay-slot flag.
REQ-013 D_ExcCode  output  5  registered fetch exception code, 0 = none, 4 = AdEL.
REQ-014 D_Valid  output  1  1 = D_Instr is a real instruction, 0 = bubble.

Function
REQ-015 All outputs SHALL be registers updated only at the rising CLK edge or by RESET; no combinational path from any input to any output.
REQ-016 Update priority SHALL be RESET > Req > (WE and Clr) > WE > hold.
REQ-017 Req=1 SHALL load D_PC=0x0000_4180, D_Instr=0, D_BD=0, D_ExcCode=0, D_Valid=0 regardless of WE and Clr.
REQ-018 Req=0, WE=1, Clr=1 SHALL load D_PC=F_PC, D_Instr=0, D_BD=F_BD, D_ExcCode=0, D_Valid=0.
REQ-019 Req=0, WE=1, Clr=0 SHALL load D_PC=F_PC, D_BD=F_BD, D_Valid=1, and D_Instr/D_ExcCode per REQ-021/REQ-022.
REQ-020 Req=0, WE=0 SHALL hold every output unchanged, including across any number of consecutive stall cycles; Clr is ignored while WE=0.
REQ-021 A fetch fault SHALL be: F_PC[1:0]!=0, or F_PC<0x0000_3000, or F_PC>0x0000_6FFC (unsigned 32-bit compare).
REQ-022 On an advancing load (REQ-019) with a fetch fault: D_ExcCode=4 and D_Instr=0; without fault: D_ExcCode=0 and D_Instr=F_Instr.
REQ-023 A faulting load SHALL still set D_Valid=1 so the fault reaches the exception-commit stage with its PC and BD flag.
REQ-024 Boundary addresses SHALL behave as: 0x0000_3000 and 0x0000_6FFC no fault; 0x0000_2FFC and 0x0000_7000 fault.
REQ-025 Req asserted while WE=0 SHALL flush per REQ-017 (flush overrides stall).

Reset
REQ-026 RESET=1 SHALL immediately, without waiting for CLK, set D_PC=0x0000_3000, D_Instr=0, D_BD=0, D_ExcCode=0, D_Valid=0.
REQ-027 While RESET=1 all inputs SHALL be ignored; the first load SHALL occur at the first rising CLK edge after RESET deasserts.
REQ-028 RESET asserted mid-stall or mid-flush SHALL discard the held or flushed state with no residue.

Configuration
REQ-029 Macro FD_EXC_CHECK_EN SHALL gate fetch-fault detection.
REQ-030 With FD_EXC_CHECK_EN defined, REQ-021 to REQ-024 apply.
REQ-031 Without FD_EXC_CHECK_EN, no fault is ever detected: D_ExcCode is constant 0 and an advancing load always sets D_Instr=F_Instr; the port list is unchanged.

Verification
REQ-032 Reset: RESET pulse between clock edges -> outputs immediately 0x0000_3000/0/0/0/0.
REQ-033 Advance: F_PC=0x3004, F_Instr=0x2408_0001, WE=1 -> next edge D_PC=0x3004, D_Instr=0x2408_0001, D_Valid=1, D_ExcCode=0.
REQ-034 Stall: WE=0 for 3 cycles while F_PC changes -> outputs hold 0x3004/0x2408_0001 throughout; Clr=1 during the stall has no effect.
REQ-035 Flush: Req=1 with WE=0 -> next edge D_PC=0x4180, D_Instr=0, D_Valid=0.
REQ-036 Fault (FD_EXC_CHECK_EN defined): F_PC=0x3002 then 0x7000 then 0x6FFC, WE=1 -> D_ExcCode 4, 4, 0; D_Instr 0, 0, F_Instr. Same stimulus without the macro -> D_ExcCode 0 each cycle.
REQ-037 Clr: WE=1, Clr=1, F_PC=0x3010, F_BD=1 -> D_PC=0x3010, D_Instr=0, D_BD=1, D_Valid=0.

Source files
------------

// File: rtl/fd_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fd_pipe_reg
//  Purpose  : Fetch/Decode pipeline register. Captures the fetched PC,
//             instruction word and delay-slot flag for the decode stage.
//             It supports stall (hold), flush toward the exception handler,
//             and squash of an annulled delay slot. It can also flag fetch
//             address faults (AdEL).
//  Ports    : CLK        rising-edge clock
//             RESET      asynchronous active-high reset
//             F_PC       fetch PC (32)
//             F_Instr    fetched instruction word (32)
//             F_BD       fetched instruction is in a branch delay slot
//             WE         stage enable (0 = stall/hold, 1 = advance)
//             Req        exception/interrupt flush request
//             Clr        squash incoming instruction when advancing
//             D_PC       decode-stage PC (32)
//             D_Instr    decode-stage instruction, 0 for bubble/fault (32)
//             D_BD       decode-stage delay-slot flag
//             D_ExcCode  fetch exception code, 0 none / 4 AdEL (5)
//             D_Valid    1 = real instruction, 0 = bubble
//  Options  : FD_EXC_CHECK_EN  when defined, enables fetch-fault detection.
//                              When undefined, D_ExcCode stays 0.
//  Revision : 1.0  initial release
// ============================================================================
module fd_pipe_reg (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] F_PC,
  input  logic [31:0] F_Instr,
  input  logic        F_BD,
  input  logic        WE,
  input  logic        Req,
  input  logic        Clr,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_BD,
  output logic [4:0]  D_ExcCode,
  output logic        D_Valid
);

  localparam logic [31:0] c_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] c_HANDLER_PC = 32'h0000_4180;
  localparam logic [4:0]  c_EXC_NONE   = 5'd0;
  localparam logic [4:0]  c_EXC_ADEL   = 5'd4;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_bd;
  logic [4:0]  r_exc;
  logic        r_valid;

  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic        w_bd;
  logic [4:0]  w_exc;
  logic        w_valid;
  logic        w_fetch_fault;

`ifdef FD_EXC_CHECK_EN
  // The legal instruction window is word-aligned and spans 0x3000..0x6FFC
  // inclusive. The compares are unsigned.
  localparam logic [31:0] c_TEXT_LO = 32'h0000_3000;
  localparam logic [31:0] c_TEXT_HI = 32'h0000_6FFC;
  assign w_fetch_fault = (F_PC[1:0] != 2'b00) ||
                         (F_PC < c_TEXT_LO)   ||
                         (F_PC > c_TEXT_HI);
`else
  assign w_fetch_fault = 1'b0;
`endif

  // Next-state selection. The priority order is flush, then squash, then
  // advance, then hold.
  always_comb begin
    w_pc    = r_pc;
    w_instr = r_instr;
    w_bd    = r_bd;
    w_exc   = r_exc;
    w_valid = r_valid;
    if (Req) begin
      // A flush overrides a stall. It injects a bubble tagged with the
      // handler PC.
      w_pc    = c_HANDLER_PC;
      w_instr = 32'h0;
      w_bd    = 1'b0;
      w_exc   = c_EXC_NONE;
      w_valid = 1'b0;
    end else if (WE) begin
      w_pc = F_PC;
      w_bd = F_BD;
      if (Clr) begin
        // An annulled delay slot keeps its PC and BD flag, but it becomes
        // a bubble.
        w_instr = 32'h0;
        w_exc   = c_EXC_NONE;
        w_valid = 1'b0;
      end else if (w_fetch_fault) begin
        // A faulting fetch stays valid, so that the fault reaches commit.
        w_instr = 32'h0;
        w_exc   = c_EXC_ADEL;
        w_valid = 1'b1;
      end else begin
        w_instr = F_Instr;
        w_exc   = c_EXC_NONE;
        w_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc    <= c_RESET_PC;
      r_instr <= 32'h0;
      r_bd    <= 1'b0;
      r_exc   <= c_EXC_NONE;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_pc;
      r_instr <= w_instr;
      r_bd    <= w_bd;
      r_exc   <= w_exc;
      r_valid <= w_valid;
    end
  end

  assign D_PC      = r_pc;
  assign D_Instr   = r_instr;
  assign D_BD      = r_bd;
  assign D_ExcCode = r_exc;
  assign D_Valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fd_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fd_pipe_reg
//  Purpose  : Self-checking bench for fd_pipe_reg. It uses a table of
//             per-cycle vectors with a scoreboard queue, plus hand-written
//             sequences for asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fd_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic [4:0]  exc;
    logic        valid;
  } out_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        clr;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] instr;
    out_t        exp;
  } vec_t;

`ifdef FD_EXC_CHECK_EN
  localparam bit c_CHK = 1'b1;
`else
  localparam bit c_CHK = 1'b0;
`endif
  localparam logic [4:0] c_FEXC = c_CHK ? 5'd4 : 5'd0;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] F_PC = 32'h0;
  logic [31:0] F_Instr = 32'h0;
  logic        F_BD = 1'b0;
  logic        WE = 1'b0;
  logic        Req = 1'b0;
  logic        Clr = 1'b0;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic        D_BD;
  logic [4:0]  D_ExcCode;
  logic        D_Valid;

  int checks = 0;
  int errors = 0;
  out_t sb[$];
  vec_t tbl[14];

  fd_pipe_reg dut (
    .CLK(CLK), .RESET(RESET), .F_PC(F_PC), .F_Instr(F_Instr), .F_BD(F_BD),
    .WE(WE), .Req(Req), .Clr(Clr), .D_PC(D_PC), .D_Instr(D_Instr),
    .D_BD(D_BD), .D_ExcCode(D_ExcCode), .D_Valid(D_Valid)
  );

  always #5 CLK = ~CLK;

  function automatic out_t mko(logic [31:0] pc, logic [31:0] instr, logic bd,
                               logic [4:0] exc, logic valid);
    out_t o;
    o.pc = pc; o.instr = instr; o.bd = bd; o.exc = exc; o.valid = valid;
    return o;
  endfunction

  function automatic vec_t mkv(logic req, logic we, logic clr, logic bd,
                               logic [31:0] pc, logic [31:0] instr, out_t e);
    vec_t v;
    v.req = req; v.we = we; v.clr = clr; v.bd = bd;
    v.pc = pc; v.instr = instr; v.exp = e;
    return v;
  endfunction

  // When fault checking is built in, a faulting fetch yields instruction 0.
  function automatic logic [31:0] finstr(logic [31:0] instr);
    return c_CHK ? 32'h0 : instr;
  endfunction

  task automatic compare(string name, out_t e);
    out_t a;
    a = {D_PC, D_Instr, D_BD, D_ExcCode, D_Valid};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got pc=%h instr=%h bd=%b exc=%0d valid=%b, want pc=%h instr=%h bd=%b exc=%0d valid=%b",
               name, a.pc, a.instr, a.bd, a.exc, a.valid,
               e.pc, e.instr, e.bd, e.exc, e.valid);
    end
  endtask

  initial begin
    // Consecutive cycles. Each row's expectation depends on the state the
    // previous rows left behind.
    tbl[0]  = mkv(0, 1, 0, 0, 32'h3004, 32'h2408_0001, mko(32'h3004, 32'h2408_0001, 0, 0, 1));
    tbl[1]  = mkv(0, 0, 0, 1, 32'h3008, 32'hAAAA_0001, mko(32'h3004, 32'h2408_0001, 0, 0, 1));
    tbl[2]  = mkv(0, 0, 1, 0, 32'h300C, 32'hAAAA_0002, mko(32'h3004, 32'h2408_0001, 0, 0, 1));
    tbl[3]  = mkv(0, 0, 0, 1, 32'h3010, 32'hAAAA_0003, mko(32'h3004, 32'h2408_0001, 0, 0, 1));
    tbl[4]  = mkv(1, 0, 0, 1, 32'h3014, 32'hAAAA_0004, mko(32'h4180, 32'h0, 0, 0, 0));
    tbl[5]  = mkv(0, 1, 0, 0, 32'h3002, 32'h1111_1111, mko(32'h3002, finstr(32'h1111_1111), 0, c_FEXC, 1));
    tbl[6]  = mkv(0, 1, 0, 0, 32'h7000, 32'h2222_2222, mko(32'h7000, finstr(32'h2222_2222), 0, c_FEXC, 1));
    tbl[7]  = mkv(0, 1, 0, 0, 32'h6FFC, 32'h3333_3333, mko(32'h6FFC, 32'h3333_3333, 0, 0, 1));
    tbl[8]  = mkv(0, 1, 0, 1, 32'h3000, 32'h4444_4444, mko(32'h3000, 32'h4444_4444, 1, 0, 1));
    tbl[9]  = mkv(0, 1, 0, 1, 32'h2FFC, 32'h5555_5555, mko(32'h2FFC, finstr(32'h5555_5555), 1, c_FEXC, 1));
    tbl[10] = mkv(0, 1, 1, 1, 32'h3010, 32'h6666_6666, mko(32'h3010, 32'h0, 1, 0, 0));
    tbl[11] = mkv(1, 1, 1, 1, 32'h3020, 32'h7777_7777, mko(32'h4180, 32'h0, 0, 0, 0));
    tbl[12] = mkv(0, 1, 0, 0, 32'h0000, 32'h8888_8888, mko(32'h0000, finstr(32'h8888_8888), 0, c_FEXC, 1));
    tbl[13] = mkv(0, 0, 1, 1, 32'h5000, 32'h9999_9999, mko(32'h0000, finstr(32'h8888_8888), 0, c_FEXC, 1));

    // Assert reset between clock edges. The outputs must change with no edge.
    #2 RESET = 1'b1;
    #1 compare("reset_async", mko(32'h3000, 0, 0, 0, 0));
    // Inputs are ignored while reset is held across an edge.
    WE = 1'b1; F_PC = 32'h3004; F_Instr = 32'h1234_5678; Req = 1'b1;
    @(posedge CLK); #1;
    compare("reset_hold", mko(32'h3000, 0, 0, 0, 0));
    @(negedge CLK);
    RESET = 1'b0; WE = 1'b0; Req = 1'b0;

    for (int i = 0; i < 14; i++) begin
      Req = tbl[i].req; WE = tbl[i].we; Clr = tbl[i].clr;
      F_BD = tbl[i].bd; F_PC = tbl[i].pc; F_Instr = tbl[i].instr;
      sb.push_back(tbl[i].exp);
      @(posedge CLK); #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: got size 0, want 1");
      end else begin
        compare($sformatf("vec%0d", i), sb.pop_front());
      end
      @(negedge CLK);
    end

    // Reset during a stall clears the held state, and the first load occurs
    // at the first edge after release.
    WE = 1'b0; Clr = 1'b0; Req = 1'b0;
    #2 RESET = 1'b1;
    #1 compare("reset_mid_stall", mko(32'h3000, 0, 0, 0, 0));
    #1 RESET = 1'b0;
    WE = 1'b1; F_PC = 32'h3100; F_Instr = 32'hCAFE_0001; F_BD = 1'b0;
    @(posedge CLK); #1;
    compare("first_load_after_reset", mko(32'h3100, 32'hCAFE_0001, 0, 0, 1));

    // Reset right after a flush leaves no residue. The stall that follows
    // keeps the reset values.
    @(negedge CLK);
    Req = 1'b1; WE = 1'b0;
    @(posedge CLK); #1;
    compare("flush", mko(32'h4180, 0, 0, 0, 0));
    Req = 1'b0;
    #1 RESET = 1'b1;
    #1 compare("reset_mid_flush", mko(32'h3000, 0, 0, 0, 0));
    #1 RESET = 1'b0;
    @(posedge CLK); #1;
    compare("stall_after_reset", mko(32'h3000, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // This bounds the run in case the clock or the scheduling misbehaves.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
